sr_layer_sequencer: RTL and testbench

- Parametrised controller for the super-resolution CNN pipeline: loads per-layer weights from the shared weight store, then sequences a configurable number of conv layers once per input pixel over a frame.
- Sits between the pixel/neighbourhood fetch logic and the layer instances (upsample, conv, ...).
- Generalises the fixed 6-layer control path with:
  - runtime per-layer weight counts,
  - skip-reload of already-loaded weights,
  - a valid/ready pixel handshake,
  - abort,
  - a sticky watchdog error.

---
 rtl/sr_layer_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_sr_layer_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_layer_sequencer.sv
// sr_layer_sequencer
//   Controller for the super-resolution CNN pipeline. On start it optionally
//   streams every layer's weights out of the shared weight store (contiguous
//   packing, layer 0 first), then sequences the conv layers once per accepted
//   input pixel until a full frame has been produced.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, reload       begin a frame (IDLE only); reload forces a weight load
//   abort               return to IDLE from any busy state
//   layer_weight_count  packed per-layer weight counts, static while busy
//   load_weights        weight word valid this cycle
//   load_layer_sel      layer receiving the current weight
//   weight_addr         global weight store address
//   weight_local_addr   index within the selected layer
//   pix_valid/pix_ready input neighbourhood handshake
//   layer_start         one-hot start pulse to the layer instances
//   layer_done          done pulses from the layer instances
//   out_valid           last layer finished a pixel (pulse)
//   pixel_count         pixels completed in the current frame
//   frame_done          frame complete (pulse)
//   busy                controller not idle
//   timeout_err         sticky watchdog flag, cleared by abort or reset
//
// Pixel handshake: a pixel is transferred in any cycle where pix_valid and
// pix_ready are both high. pix_ready is only raised in WAIT_PIX and drops the
// cycle after a transfer; pix_valid may be held high across pixels.

module sr_layer_sequencer #(
  parameter int NUM_LAYERS        = 6,
  parameter int WEIGHT_ADDR_WIDTH = 18,
  parameter int LAYER_CNT_WIDTH   = 12,
  parameter int PIX_CNT_WIDTH     = 17,
  parameter int FRAME_PIXELS      = 76800,
  parameter int TIMEOUT_CYCLES    = 1000000,
  localparam int LSEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  reload,
  input  logic                                  abort,
  input  logic [NUM_LAYERS*LAYER_CNT_WIDTH-1:0] layer_weight_count,
  output logic                                  load_weights,
  output logic [LSEL_W-1:0]                     load_layer_sel,
  output logic [WEIGHT_ADDR_WIDTH-1:0]          weight_addr,
  output logic [LAYER_CNT_WIDTH-1:0]            weight_local_addr,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  output logic [NUM_LAYERS-1:0]                 layer_start,
  input  logic [NUM_LAYERS-1:0]                 layer_done,
  output logic                                  out_valid,
  output logic [PIX_CNT_WIDTH-1:0]              pixel_count,
  output logic                                  frame_done,
  output logic                                  busy,
  output logic                                  timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_PIX,
    S_RUN,
    S_FDONE,
    S_ERR
  } state_t;

  state_t              state;
  logic                weights_loaded;
  logic [LSEL_W-1:0]   cur;
  logic [WD_W-1:0]     wd;

  logic                 first_found;
  logic [LSEL_W-1:0]    first_idx;
  logic                 next_found;
  logic [LSEL_W-1:0]    next_idx;
  logic [LAYER_CNT_WIDTH-1:0] cur_cnt;
  logic                 done_cur;
  logic [WD_W-1:0]      wd_inc;

  // Zero-count layers are skipped without a gap: first_idx is the lowest
  // layer with weights, next_idx the lowest one above the layer being loaded.
  // The descending walk leaves the smallest matching index in each result.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    cur_cnt     = '0;
    done_cur    = 1'b0;
    for (int j = NUM_LAYERS - 1; j >= 0; j--) begin
      if (layer_weight_count[j*LAYER_CNT_WIDTH +: LAYER_CNT_WIDTH] != '0) begin
        first_found = 1'b1;
        first_idx   = LSEL_W'(j);
        if (j > int'(load_layer_sel)) begin
          next_found = 1'b1;
          next_idx   = LSEL_W'(j);
        end
      end
      if (LSEL_W'(j) == load_layer_sel) begin
        cur_cnt = layer_weight_count[j*LAYER_CNT_WIDTH +: LAYER_CNT_WIDTH];
      end
      // Only the layer currently running may advance the sequence.
      if (LSEL_W'(j) == cur) begin
        done_cur = layer_done[j];
      end
    end
    wd_inc = wd + WD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      weights_loaded    <= 1'b0;
      cur               <= '0;
      wd                <= '0;
      load_weights      <= 1'b0;
      load_layer_sel    <= '0;
      weight_addr       <= '0;
      weight_local_addr <= '0;
      pix_ready         <= 1'b0;
      layer_start       <= '0;
      out_valid         <= 1'b0;
      pixel_count       <= '0;
      frame_done        <= 1'b0;
      busy              <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      layer_start <= '0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      if (abort && state != S_IDLE) begin
        // A partial load leaves the layers' weight memories inconsistent.
        if (state == S_LOAD) weights_loaded <= 1'b0;
        state        <= S_IDLE;
        busy         <= 1'b0;
        load_weights <= 1'b0;
        pix_ready    <= 1'b0;
        timeout_err  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              busy        <= 1'b1;
              pixel_count <= '0;
              if (reload || !weights_loaded) begin
                state             <= S_LOAD;
                load_weights      <= first_found;
                load_layer_sel    <= first_idx;
                weight_local_addr <= '0;
                weight_addr       <= '0;
              end else begin
                state <= S_WAIT_PIX;
              end
            end
          end
          S_LOAD: begin
            if (load_weights &&
                weight_local_addr != cur_cnt - LAYER_CNT_WIDTH'(1)) begin
              weight_local_addr <= weight_local_addr + LAYER_CNT_WIDTH'(1);
              weight_addr       <= weight_addr + WEIGHT_ADDR_WIDTH'(1);
            end else if (load_weights && next_found) begin
              load_layer_sel    <= next_idx;
              weight_local_addr <= '0;
              weight_addr       <= weight_addr + WEIGHT_ADDR_WIDTH'(1);
            end else begin
              // Last weight issued, or nothing to load at all.
              load_weights   <= 1'b0;
              weights_loaded <= 1'b1;
              state          <= S_WAIT_PIX;
            end
          end
          S_WAIT_PIX: begin
            if (pix_valid && pix_ready) begin
              pix_ready      <= 1'b0;
              layer_start[0] <= 1'b1;
              cur            <= '0;
              wd             <= '0;
              state          <= S_RUN;
            end else begin
              pix_ready <= 1'b1;
            end
          end
          S_RUN: begin
            if (done_cur) begin
              wd <= '0;
              if (cur == LSEL_W'(NUM_LAYERS - 1)) begin
                out_valid   <= 1'b1;
                pixel_count <= pixel_count + PIX_CNT_WIDTH'(1);
                state <= (pixel_count == PIX_CNT_WIDTH'(FRAME_PIXELS - 1)) ?
                         S_FDONE : S_WAIT_PIX;
              end else begin
                layer_start <= NUM_LAYERS'(1) << (cur + LSEL_W'(1));
                cur         <= cur + LSEL_W'(1);
              end
            end else begin
              wd <= wd_inc;
              if (wd_inc == WD_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_err <= 1'b1;
                state       <= S_ERR;
              end
            end
          end
          S_FDONE: begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
          S_ERR: begin
            // Parked until abort or reset.
            state <= S_ERR;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sr_layer_sequencer.sv
// Bench for sr_layer_sequencer with NUM_LAYERS=3, FRAME_PIXELS=2,
// TIMEOUT_CYCLES=16. Expected weight-load words come from nested loops over
// the per-layer counts; the bench plays the layer instances and predicts
// start order, out_valid, pixel_count and frame_done from the frame rules.

module tb_sr_layer_sequencer;
  localparam int NL  = 3;
  localparam int LCW = 12;
  localparam int WAW = 18;
  localparam int PCW = 17;
  localparam int FP  = 2;
  localparam int TO  = 16;
  localparam int LSW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              reload = 1'b0;
  logic              abort = 1'b0;
  logic [NL*LCW-1:0] layer_weight_count = '0;
  logic              load_weights;
  logic [LSW-1:0]    load_layer_sel;
  logic [WAW-1:0]    weight_addr;
  logic [LCW-1:0]    weight_local_addr;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic [NL-1:0]     layer_start;
  logic [NL-1:0]     layer_done = '0;
  logic              out_valid;
  logic [PCW-1:0]    pixel_count;
  logic              frame_done;
  logic              busy;
  logic              timeout_err;

  sr_layer_sequencer #(
    .NUM_LAYERS(NL), .WEIGHT_ADDR_WIDTH(WAW), .LAYER_CNT_WIDTH(LCW),
    .PIX_CNT_WIDTH(PCW), .FRAME_PIXELS(FP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reload(reload), .abort(abort),
    .layer_weight_count(layer_weight_count), .load_weights(load_weights),
    .load_layer_sel(load_layer_sel), .weight_addr(weight_addr),
    .weight_local_addr(weight_local_addr), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .layer_start(layer_start), .layer_done(layer_done),
    .out_valid(out_valid), .pixel_count(pixel_count), .frame_done(frame_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  // scoreboard state
  logic [31:0] exp_q[$];     // {sel, local, addr} per expected load cycle
  int          start_q[$];   // expected order of layer starts
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cnt[NL];
  int due[NL];
  int ls_cyc[NL];
  logic [NL-1:0] resp_en = '1;
  int lat_mode = 0;
  int fix_lat = 3;
  int pv_mode = 0;
  int n_load, load_first, load_last;
  int pix_model, n_ov;
  int ov_due = -1;
  int fd_due = -1;
  int exp_ls0 = -1;
  int fd_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_bench();
    exp_q.delete();
    start_q.delete();
    for (int i = 0; i < NL; i++) begin
      due[i] = -1;
      ls_cyc[i] = -1;
    end
    ov_due = -1;
    fd_due = -1;
    exp_ls0 = -1;
    resp_en = '1;
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2;
    for (int l = 0; l < NL; l++) layer_weight_count[l*LCW +: LCW] = LCW'(cnt[l]);
  endtask

  // Contiguous packing: layer l's weights follow all lower layers' weights.
  task automatic expect_load(output int total);
    total = 0;
    exp_q.delete();
    for (int l = 0; l < NL; l++) begin
      for (int k = 0; k < cnt[l]; k++) begin
        exp_q.push_back({LSW'(l), LCW'(k), WAW'(total)});
        total++;
      end
    end
  endtask

  // One clock: sample at the falling edge, check, then drive the next inputs.
  task automatic step();
    logic [31:0] exp_w;
    int li;
    @(negedge clk);
    cyc++;
    if (load_weights) begin
      n_load++;
      if (load_first < 0) load_first = cyc;
      load_last = cyc;
      if (exp_q.size() == 0) check_eq("load_extra", 32'(load_weights), 32'd0);
      else begin
        exp_w = exp_q.pop_front();
        check_eq("load_word", {load_layer_sel, weight_local_addr, weight_addr}, exp_w);
      end
    end
    if (layer_start != '0) begin
      check_eq("start_onehot", $countones(layer_start), 1);
      if (start_q.size() == 0) check_eq("start_extra", 32'(layer_start), 32'd0);
      else begin
        li = start_q.pop_front();
        check_eq("start_order", 32'(layer_start), 32'(1 << li));
      end
      if (layer_start[0]) check_eq("start0_latency", cyc, exp_ls0);
      for (int i = 0; i < NL; i++) begin
        if (layer_start[i]) begin
          ls_cyc[i] = cyc;
          if (resp_en[i]) due[i] = cyc + ((lat_mode != 0) ? int'($urandom_range(1, 4)) : fix_lat);
        end
      end
    end
    if (out_valid || cyc == ov_due) begin
      check_eq("out_valid", 32'(out_valid), 32'(cyc == ov_due));
      if (out_valid) begin
        n_ov++;
        pix_model++;
        check_eq("pixel_count", 32'(pixel_count), pix_model);
        if (pix_model == FP) fd_due = cyc + 1;
      end
    end
    if (frame_done || cyc == fd_due) begin
      check_eq("frame_done", 32'(frame_done), 32'(cyc == fd_due));
      if (frame_done) begin
        fd_seen = 1;
        check_eq("fdone_busy", 32'(busy), 32'd0);
      end
    end
    // layer responder
    layer_done = '0;
    for (int i = 0; i < NL; i++) begin
      if (due[i] == cyc) begin
        layer_done[i] = 1'b1;
        due[i] = -1;
        if (i == NL - 1) ov_due = cyc + 1;
      end
    end
    // pixel source
    case (pv_mode)
      0:       pix_valid = 1'b0;
      1:       pix_valid = 1'b1;
      default: pix_valid = 1'($urandom_range(0, 1));
    endcase
    if (pix_valid && pix_ready) begin
      for (int i = 0; i < NL; i++) start_q.push_back(i);
      exp_ls0 = cyc + 1;
    end
  endtask

  task automatic run_load(input logic rl, input int exp_total, input int exp_rise);
    int c0;
    int t;
    n_load = 0; load_first = -1; load_last = -1;
    pix_model = 0; n_ov = 0; fd_seen = 0;
    c0 = cyc;
    start = 1'b1;
    reload = rl;
    step();
    start = 1'b0;
    reload = 1'b0;
    t = 0;
    while (!pix_ready && t < 60) begin
      step();
      t++;
    end
    check_eq("ready_rise", cyc - c0, exp_rise);
    check_eq("load_cycles", n_load, exp_total);
    check_eq("load_left", exp_q.size(), 0);
    if (exp_total > 0) begin
      check_eq("load_first", load_first - c0, 1);
      check_eq("load_span", load_last - load_first + 1, exp_total);
    end
    check_eq("pix_cnt_clear", 32'(pixel_count), 32'd0);
  endtask

  task automatic run_frame(input int pvm, input int lm);
    int t;
    pv_mode = pvm;
    lat_mode = lm;
    fix_lat = 3;
    t = 0;
    while (fd_seen == 0 && t < 500) begin
      step();
      t++;
    end
    pv_mode = 0;
    check_eq("frame_seen", fd_seen, 1);
    check_eq("ov_total", n_ov, FP);
    step();
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("count_hold", 32'(pixel_count), FP);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_load"}, 32'(load_weights), 32'd0);
    check_eq({tag, "_addr"}, 32'(weight_addr), 32'd0);
    check_eq({tag, "_ready"}, 32'(pix_ready), 32'd0);
    check_eq({tag, "_lstart"}, 32'(layer_start), 32'd0);
    check_eq({tag, "_ov"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_pixcnt"}, 32'(pixel_count), 32'd0);
    check_eq({tag, "_fdone"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int total;
    int t;
    clear_bench();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Full load with a zero-count middle layer, then one frame.
    set_counts(4, 0, 2);
    expect_load(total);
    run_load(1'b1, total, total + 2);
    run_frame(1, 0);

    // Weights already resident: no load, random pixel gaps and latencies.
    clear_bench();
    run_load(1'b0, 0, 2);
    run_frame(2, 1);

    // Out-of-turn done is ignored; withheld layer 1 trips the watchdog.
    clear_bench();
    run_load(1'b0, 0, 2);
    resp_en = 3'b101;
    lat_mode = 0;
    fix_lat = 5;
    pv_mode = 1;
    t = 0;
    while (ls_cyc[0] < 0 && t < 20) begin step(); t++; end
    pv_mode = 0;
    step();
    step();
    layer_done[2] = 1'b1;
    t = 0;
    while (!timeout_err && t < 60) begin step(); t++; end
    check_eq("wd_span", cyc - ls_cyc[1], TO - 1);
    start = 1'b1;
    pv_mode = 1;
    repeat (3) begin
      step();
      check_eq("err_busy", 32'(busy), 32'd1);
      check_eq("err_terr", 32'(timeout_err), 32'd1);
      check_eq("err_ready", 32'(pix_ready), 32'd0);
    end
    start = 1'b0;
    pv_mode = 0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_terr", 32'(timeout_err), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);

    // Abort in the third load cycle forces a complete reload afterwards.
    clear_bench();
    set_counts(4, 0, 2);
    expect_load(total);
    n_load = 0; load_first = -1; load_last = -1;
    start = 1'b1;
    reload = 1'b1;
    step();
    start = 1'b0;
    reload = 1'b0;
    step();
    step();
    check_eq("abort_at_addr", 32'(weight_addr), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abortl_load", 32'(load_weights), 32'd0);
    check_eq("abortl_busy", 32'(busy), 32'd0);
    check_eq("abortl_nload", n_load, 3);
    expect_load(total);
    run_load(1'b0, total, total + 2);
    run_frame(1, 1);

    // Reset during RUN of the second pixel, then a load is required again.
    clear_bench();
    run_load(1'b0, 0, 2);
    lat_mode = 0;
    fix_lat = 3;
    pv_mode = 1;
    t = 0;
    while (n_ov < 1 && t < 60) begin step(); t++; end
    ls_cyc[1] = -1;
    t = 0;
    while (ls_cyc[1] < 0 && t < 60) begin step(); t++; end
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    pv_mode = 0;
    clear_bench();
    step();
    rst_n = 1'b1;
    expect_load(total);
    run_load(1'b0, total, total + 2);
    run_frame(2, 1);

    // Random weight counts, including possible all-zero configurations.
    for (int it = 0; it < 4; it++) begin
      clear_bench();
      set_counts(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
      if (it == 3) set_counts(0, 0, 0);
      expect_load(total);
      run_load(1'b1, total, (total == 0) ? 3 : total + 2);
      run_frame(2, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
